character_redraw_controller: RTL and testbench
==============================================

CHARACTER_REDRAW_CONTROLLER -- requirements
Module: character_redraw_controller

Interface
REQ-001 Parameter BASE_Y, default 102, SHALL give the character's top row on screen.
REQ-002 Parameter BG_COLOR, default 3'b111, SHALL give the erase colour.
REQ-003 Clock  in  1  SHALL be the only clock; all state SHALL update on its rising edge.
REQ-004 Reset  in  1  SHALL be synchronous and active-low.
REQ-005 MoveReq  in  1  SHALL be a level request to move the character to NewPos.
REQ-006 NewPos  in  2  SHALL be the target slot: 0..3 map to X = 6, 24, 78, 132.
REQ-007 DrawColor  in  3  SHALL be the character fill colour.
REQ-008 FrameTick  in  1  SHALL be a one-cycle frame-start strobe, used only under REQ-024.
REQ-009 Busy  out  1  SHALL be high from acceptance until Done.
REQ-010 Done  out  1  SHALL be a one-cycle completion pulse.
REQ-011 XOut, YOut, ColorOut, Plot  out  8, 7, 3, 1  SHALL form the pixel write port; XOut/YOut/ColorOut SHALL be valid when Plot=1.
REQ-012 CurrPos  out  2  SHALL be the slot currently drawn on screen.

Function
REQ-013 States SHALL be IDLE, ERASE, DRAW, DONE, plus WAIT_FRAME under REQ-024.
REQ-014 In IDLE with MoveReq=1, the block SHALL accept: latch NewPos and DrawColor, assert Busy the next cycle, and enter ERASE (or DRAW per REQ-017).
REQ-015 ERASE and DRAW SHALL each raster a 9x5 box: X fastest (col 0..8), then row 0..4. Each box takes 45 cycles with Plot=1 every cycle.
REQ-016 ERASE SHALL use the X of CurrPos and ColorOut=BG_COLOR. DRAW SHALL use the X of the latched NewPos and the latched DrawColor. YOut SHALL equal BASE_Y+row.
REQ-017 If the latched NewPos equals CurrPos, ERASE SHALL be skipped.
REQ-018 The first Plot SHALL occur one cycle after acceptance. With erase, the last Plot SHALL occur at acceptance+90 and Done at acceptance+91. Without erase, Done SHALL occur at acceptance+46.
REQ-019 In DONE the block SHALL update CurrPos to the latched NewPos, pulse Done, drop Busy, and return to IDLE. It SHALL not accept a new request in the same cycle.
REQ-020 MoveReq, NewPos and DrawColor SHALL be ignored while Busy=1. A request held through DONE SHALL be accepted on the first IDLE cycle.
REQ-021 Plot SHALL be 0 in IDLE, WAIT_FRAME and DONE. XOut/YOut SHALL hold their last values when Plot=0.

Reset
REQ-022 On Reset=0 the block SHALL enter IDLE. Busy, Done, Plot, XOut, YOut, ColorOut and the raster counters SHALL be 0, and CurrPos SHALL be 0.
REQ-023 Reset mid-ERASE or mid-DRAW SHALL abort within one cycle: Plot=0 and no Done pulse.

Configuration
REQ-024 With VSYNC_GATE_EN defined, acceptance SHALL enter WAIT_FRAME and start ERASE/DRAW on the cycle after the first FrameTick=1. A FrameTick in the acceptance cycle itself SHALL not count. Latencies in REQ-018 SHALL then be measured from that FrameTick.
REQ-025 Without VSYNC_GATE_EN, FrameTick SHALL be ignored and WAIT_FRAME SHALL not exist.

Verification
REQ-026 Reset, then MoveReq=1 with NewPos=2, DrawColor=3'b100 -> 45 Plots at X 6..14, Y 102..106, colour 111; then 45 Plots at X 78..86, colour 100; Done at +91; CurrPos=2.
REQ-027 CurrPos=2, request NewPos=2 -> no erase; 45 draw Plots at X 78..86; Done at +46.
REQ-028 Second MoveReq with NewPos=3 pulsed mid-DRAW -> ignored; CurrPos stays at the first target; no extra Plots.
REQ-029 Reset=0 at cycle 20 of ERASE -> Plot=0 and Busy=0 next cycle; no Done; CurrPos=0.
REQ-030 VSYNC_GATE_EN defined, request at t, FrameTick at t+10 -> Busy from t+1; no Plot before t+11; first Plot at t+11.
REQ-031 MoveReq held high continuously -> each move separated by exactly one IDLE cycle after DONE, with Busy low in that cycle.

Source files
------------

// File: rtl/character_redraw_controller.sv
// Erases the character box at its current slot and redraws it at a new slot.
// Optional VSYNC_GATE_EN holds the redraw until the next FrameTick.
module character_redraw_controller #(
    parameter int         BASE_Y   = 102,
    parameter logic [2:0] BG_COLOR = 3'b111
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       MoveReq,
    input  logic [1:0] NewPos,
    input  logic [2:0] DrawColor,
    input  logic       FrameTick,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] XOut,
    output logic [6:0] YOut,
    output logic [2:0] ColorOut,
    output logic       Plot,
    output logic [1:0] CurrPos
);

    localparam logic [6:0] Y0 = 7'(BASE_Y);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
`ifdef VSYNC_GATE_EN
        S_WAIT,
`endif
        S_DONE
    } state_t;

    state_t     state;
    logic [3:0] col;
    logic [2:0] row;
    logic [1:0] tgt;
    logic [2:0] tcol;

    logic [3:0] nxt_col;
    logic [2:0] nxt_row;
    logic       last;
    logic [1:0] start_pos;
    logic [2:0] start_color;
    logic       skip_erase;

    function automatic logic [7:0] slot_x(input logic [1:0] p);
        logic [7:0] x;
        unique case (p)
            2'd0:    x = 8'd6;
            2'd1:    x = 8'd24;
            2'd2:    x = 8'd78;
            default: x = 8'd132;
        endcase
        return x;
    endfunction

    always_comb begin
        last    = (col == 4'd8) && (row == 3'd4);
        nxt_col = (col == 4'd8) ? 4'd0 : col + 4'd1;
        nxt_row = (col == 4'd8) ? row + 3'd1 : row;
    end

    // The box start is taken from live inputs in IDLE, or from the latch after a frame wait.
`ifdef VSYNC_GATE_EN
    always_comb begin
        start_pos   = tgt;
        start_color = tcol;
        skip_erase  = (tgt == CurrPos);
    end
`else
    logic unused_tick;
    assign unused_tick = FrameTick;

    always_comb begin
        start_pos   = NewPos;
        start_color = DrawColor;
        skip_erase  = (NewPos == CurrPos);
    end
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state    <= S_IDLE;
            col      <= 4'd0;
            row      <= 3'd0;
            tgt      <= 2'd0;
            tcol     <= 3'd0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Plot     <= 1'b0;
            XOut     <= 8'd0;
            YOut     <= 7'd0;
            ColorOut <= 3'd0;
            CurrPos  <= 2'd0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    Plot <= 1'b0;
                    if (MoveReq) begin
                        tgt  <= NewPos;
                        tcol <= DrawColor;
                        Busy <= 1'b1;
`ifdef VSYNC_GATE_EN
                        state <= S_WAIT;
`else
                        col  <= 4'd0;
                        row  <= 3'd0;
                        Plot <= 1'b1;
                        YOut <= Y0;
                        if (skip_erase) begin
                            state    <= S_DRAW;
                            XOut     <= slot_x(start_pos);
                            ColorOut <= start_color;
                        end else begin
                            state    <= S_ERASE;
                            XOut     <= slot_x(CurrPos);
                            ColorOut <= BG_COLOR;
                        end
`endif
                    end
                end
`ifdef VSYNC_GATE_EN
                S_WAIT: begin
                    Plot <= 1'b0;
                    if (FrameTick) begin
                        col  <= 4'd0;
                        row  <= 3'd0;
                        Plot <= 1'b1;
                        YOut <= Y0;
                        if (skip_erase) begin
                            state    <= S_DRAW;
                            XOut     <= slot_x(start_pos);
                            ColorOut <= start_color;
                        end else begin
                            state    <= S_ERASE;
                            XOut     <= slot_x(CurrPos);
                            ColorOut <= BG_COLOR;
                        end
                    end
                end
`endif
                S_ERASE: begin
                    Plot <= 1'b1;
                    if (last) begin
                        state    <= S_DRAW;
                        col      <= 4'd0;
                        row      <= 3'd0;
                        XOut     <= slot_x(tgt);
                        YOut     <= Y0;
                        ColorOut <= tcol;
                    end else begin
                        col  <= nxt_col;
                        row  <= nxt_row;
                        XOut <= slot_x(CurrPos) + {4'd0, nxt_col};
                        YOut <= Y0 + {4'd0, nxt_row};
                    end
                end
                S_DRAW: begin
                    if (last) begin
                        state   <= S_DONE;
                        col     <= 4'd0;
                        row     <= 3'd0;
                        Plot    <= 1'b0;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        CurrPos <= tgt;
                    end else begin
                        Plot <= 1'b1;
                        col  <= nxt_col;
                        row  <= nxt_row;
                        XOut <= slot_x(tgt) + {4'd0, nxt_col};
                        YOut <= Y0 + {4'd0, nxt_row};
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    Plot  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    Plot  <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_character_redraw_controller.sv
// Bench for character_redraw_controller: directed move table, corner
// sequences and random traffic against a queue-based pixel model.
module tb_character_redraw_controller;

    localparam int BASE_Y = 102;
`ifdef VSYNC_GATE_EN
    localparam int VS = 1;
`else
    localparam int VS = 0;
`endif

    logic       Clock;
    logic       Reset;
    logic       MoveReq;
    logic [1:0] NewPos;
    logic [2:0] DrawColor;
    logic       FrameTick;
    logic       Busy;
    logic       Done;
    logic [7:0] XOut;
    logic [6:0] YOut;
    logic [2:0] ColorOut;
    logic       Plot;
    logic [1:0] CurrPos;

    int total = 0;
    int bad   = 0;

    character_redraw_controller #(
        .BASE_Y  (BASE_Y),
        .BG_COLOR(3'b111)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .MoveReq  (MoveReq),
        .NewPos   (NewPos),
        .DrawColor(DrawColor),
        .FrameTick(FrameTick),
        .Busy     (Busy),
        .Done     (Done),
        .XOut     (XOut),
        .YOut     (YOut),
        .ColorOut (ColorOut),
        .Plot     (Plot),
        .CurrPos  (CurrPos)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic       busy;
        logic       done;
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic [1:0] cur;
    } rec_t;

    rec_t       q[$];
    rec_t       exp_r;
    logic [1:0] mcur;
    logic       mwait;
    logic [1:0] mpos;
    logic [2:0] mcol;

    function automatic int slot(input logic [1:0] p);
        case (p)
            2'd0:    return 6;
            2'd1:    return 24;
            2'd2:    return 78;
            default: return 132;
        endcase
    endfunction

    // Expand one move into the per-cycle outputs it must produce.
    function automatic void fill(input logic [1:0] p, input logic [2:0] col);
        rec_t r;
        if (p != mcur) begin
            for (int rr = 0; rr < 5; rr++)
                for (int cc = 0; cc < 9; cc++) begin
                    r = '{1'b1, 1'b0, 1'b1, 8'(slot(mcur) + cc),
                          7'(BASE_Y + rr), 3'b111, mcur};
                    q.push_back(r);
                end
        end
        for (int rr = 0; rr < 5; rr++)
            for (int cc = 0; cc < 9; cc++) begin
                r = '{1'b1, 1'b0, 1'b1, 8'(slot(p) + cc),
                      7'(BASE_Y + rr), col, mcur};
                q.push_back(r);
            end
        r.busy = 1'b0;
        r.done = 1'b1;
        r.plot = 1'b0;
        r.cur  = p;
        q.push_back(r);
        r.done = 1'b0;
        q.push_back(r);
        mcur = p;
    endfunction

    initial begin
        mcur  = 2'd0;
        mwait = 1'b0;
        forever begin
            @(posedge Clock);
            if (!Reset) begin
                q.delete();
                mwait = 1'b0;
                mcur  = 2'd0;
                exp_r = '{1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 2'd0};
            end else if (q.size() != 0) begin
                exp_r = q.pop_front();
            end else if (mwait) begin
                if (FrameTick) begin
                    fill(mpos, mcol);
                    exp_r = q.pop_front();
                    mwait = 1'b0;
                end
            end else if (MoveReq) begin
`ifdef VSYNC_GATE_EN
                mwait      = 1'b1;
                mpos       = NewPos;
                mcol       = DrawColor;
                exp_r.busy = 1'b1;
                exp_r.done = 1'b0;
                exp_r.plot = 1'b0;
`else
                fill(NewPos, DrawColor);
                exp_r = q.pop_front();
`endif
            end else begin
                exp_r.busy = 1'b0;
                exp_r.done = 1'b0;
                exp_r.plot = 1'b0;
                exp_r.cur  = mcur;
            end
            @(negedge Clock);
            total++;
            if (Busy !== exp_r.busy || Done !== exp_r.done ||
                Plot !== exp_r.plot || CurrPos !== exp_r.cur ||
                XOut !== exp_r.x || YOut !== exp_r.y ||
                (exp_r.plot && ColorOut !== exp_r.c)) begin
                bad++;
                $display("FAIL cycle t=%0t got busy=%b done=%b plot=%b x=%0d y=%0d c=%b cur=%0d need busy=%b done=%b plot=%b x=%0d y=%0d c=%b cur=%0d",
                         $time, Busy, Done, Plot, XOut, YOut, ColorOut, CurrPos,
                         exp_r.busy, exp_r.done, exp_r.plot, exp_r.x, exp_r.y,
                         exp_r.c, exp_r.cur);
            end
        end
    end

    task automatic check(input string name, input int got, input int need);
        total++;
        if (got != need) begin
            bad++;
            $display("FAIL %s got=%0d need=%0d", name, got, need);
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        @(negedge Clock);
        while ((Busy || Done) && w < 300) begin
            @(negedge Clock);
            w++;
        end
        check("idle_wait", int'(w < 300), 1);
    endtask

    task automatic do_move(input logic [1:0] p, input logic [2:0] col,
                           input int intr_k, output int lat);
        wait_idle();
        NewPos    = p;
        DrawColor = col;
        MoveReq   = 1'b1;
        @(posedge Clock);
        lat = -1;
        for (int k = 1; k <= 250; k++) begin
            @(negedge Clock);
            if (k == 1) MoveReq = 1'b0;
            if (intr_k != 0 && k == intr_k) begin
                MoveReq   = 1'b1;
                NewPos    = 2'd3;
                DrawColor = ~col;
            end
            if (intr_k != 0 && k == intr_k + 1) MoveReq = 1'b0;
            if (Done) begin
                lat = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0] pos;
        logic [2:0] col;
        int         intr;
        int         lat;
        logic [1:0] cur;
    } vec_t;

    vec_t vecs[7];
    int   lat;
    int   seen;

    initial begin
        vecs[0] = '{2'd2, 3'b100, 0,  91, 2'd2};
        vecs[1] = '{2'd2, 3'b010, 0,  46, 2'd2};
        vecs[2] = '{2'd1, 3'b001, 60, 91, 2'd1};
        vecs[3] = '{2'd0, 3'b110, 0,  91, 2'd0};
        vecs[4] = '{2'd0, 3'b011, 0,  46, 2'd0};
        vecs[5] = '{2'd3, 3'b101, 0,  91, 2'd3};
        vecs[6] = '{2'd3, 3'b000, 70, 46, 2'd3};

        Reset     = 1'b0;
        MoveReq   = 1'b0;
        NewPos    = 2'd0;
        DrawColor = 3'd0;
        FrameTick = 1'b0;
        repeat (2) @(negedge Clock);
        check("reset_busy", int'(Busy), 0);
        check("reset_plot", int'(Plot), 0);
        check("reset_xy", int'({XOut, YOut, ColorOut, Done}), 0);
        check("reset_curr", int'(CurrPos), 0);
        Reset     = 1'b1;
        FrameTick = (VS == 1);

        foreach (vecs[i]) begin
            do_move(vecs[i].pos, vecs[i].col, vecs[i].intr, lat);
            check("move_latency", lat, vecs[i].lat + VS);
            check("move_currpos", int'(CurrPos), int'(vecs[i].cur));
        end

        // Reset in the middle of an erase pass.
        wait_idle();
        NewPos  = 2'd1;
        MoveReq = 1'b1;
        @(posedge Clock);
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clock);
            if (k == 1) MoveReq = 1'b0;
        end
        check("erase_plot_before_reset", int'(Plot), 1);
        Reset = 1'b0;
        @(negedge Clock);
        check("abort_plot", int'(Plot), 0);
        check("abort_busy", int'(Busy), 0);
        check("abort_curr", int'(CurrPos), 0);
        Reset = 1'b1;
        seen  = 0;
        repeat (120) begin
            @(negedge Clock);
            if (Done) seen++;
        end
        check("abort_no_done", seen, 0);

        // Continuous request: one idle cycle between moves.
        wait_idle();
        MoveReq = 1'b1;
        NewPos  = 2'd2;
        seen    = 0;
        for (int k = 0; k < 300 && !Done; k++) @(negedge Clock);
        check("held_done_seen", int'(Done), 1);
        NewPos = 2'd0;
        @(negedge Clock);
        check("held_gap_busy", int'(Busy), 0);
        check("held_gap_plot", int'(Plot), 0);
        @(negedge Clock);
        check("held_reaccept_busy", int'(Busy), 1);
        repeat (250) begin
            NewPos = 2'($urandom_range(0, 3));
            @(negedge Clock);
        end
        MoveReq = 1'b0;

`ifdef VSYNC_GATE_EN
        FrameTick = 1'b0;
        wait_idle();
        NewPos    = CurrPos + 2'd1;
        MoveReq   = 1'b1;
        FrameTick = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        MoveReq   = 1'b0;
        FrameTick = 1'b0;
        check("vs_busy_t1", int'(Busy), 1);
        seen = 0;
        for (int k = 2; k <= 10; k++) begin
            FrameTick = (k == 10);
            @(negedge Clock);
            if (Plot) seen++;
        end
        FrameTick = 1'b0;
        check("vs_no_early_plot", seen, 0);
        check("vs_first_plot", int'(Plot), 1);
`endif

        // Random traffic checked cycle by cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clock);
            MoveReq   = ($urandom_range(0, 3) == 0);
            NewPos    = 2'($urandom_range(0, 3));
            DrawColor = 3'($urandom_range(0, 7));
            FrameTick = ($urandom_range(0, 7) == 0);
            Reset     = ($urandom_range(0, 299) != 0);
        end
        Reset   = 1'b1;
        MoveReq = 1'b0;
        repeat (3) @(negedge Clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
